// File: rtl/hunt_round_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : hunt_round_ctl
//  Purpose  : Duck round scheduler. It runs the dog intro, then repeats
//             hunt -> (kill | escape) display -> next round. It also owns
//             the hunt timeout, the escaped-duck (enemy) score and the
//             round counter.
//  Revision : 1.0  initial release
// ============================================================================
module hunt_round_ctl #(
   parameter int HUNT_CYCLES = 325_000_000,
   parameter int SHOW_CYCLES = 97_500_000,
   parameter int ROUNDS      = 20,
   parameter int TIMER_W     = 32,
   parameter int SCORE_MAX   = 99
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       game_enable,
   input  logic       game_start,
   input  logic       intro_done,
   input  logic       duck_killed,
   input  logic       out_of_ammo,
   output logic       hunt_start,
   output logic       dog_bird_enable,
   output logic       duck_escape,
   output logic       escape_pulse,
   output logic [6:0] round_cnt,
   output logic [6:0] enemy_score,
   output logic       rounds_done
);

   localparam logic [TIMER_W-1:0] HUNT_LAST  = TIMER_W'(HUNT_CYCLES - 1);
   localparam logic [TIMER_W-1:0] SHOW_LAST  = TIMER_W'(SHOW_CYCLES - 1);
   localparam logic [6:0]         ROUND_LAST = 7'(ROUNDS - 1);
   localparam logic [6:0]         ROUND_TOP  = 7'(ROUNDS);
   localparam logic [6:0]         SCORE_TOP  = 7'(SCORE_MAX);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_INTRO   = 3'd1,
      S_HUNT    = 3'd2,
      S_KILLED  = 3'd3,
      S_ESCAPED = 3'd4,
      S_NEXT    = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   state_t             state;
   state_t             state_nx;
   logic [TIMER_W-1:0] timer;
   logic [TIMER_W-1:0] timer_nx;
   logic [6:0]         round_nx;
   logic [6:0]         score_nx;
   logic               enter_escape;

   // Next-state, timer and score/round update logic
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:    if (game_start) state_nx = S_INTRO;
         S_INTRO:   if (intro_done) state_nx = S_HUNT;
         S_HUNT: begin
            // A kill wins over both ammo exhaustion and the timeout
            if (duck_killed)                           state_nx = S_KILLED;
            else if (out_of_ammo || timer == HUNT_LAST) state_nx = S_ESCAPED;
         end
         S_KILLED,
         S_ESCAPED: if (timer == SHOW_LAST) state_nx = S_NEXT;
         S_NEXT: begin
            // round_cnt still holds the pre-increment value here
            if (round_cnt >= ROUND_LAST || out_of_ammo) state_nx = S_DONE;
            else                                        state_nx = S_HUNT;
         end
         S_DONE:    state_nx = S_DONE;
         default:   state_nx = S_IDLE;
      endcase
      // Dropping the stage enable aborts the game from anywhere
      if (state != S_IDLE && !game_enable) state_nx = S_IDLE;

      // Timer restarts on every state entry and only runs in timed states
      if (state_nx != state)
         timer_nx = '0;
      else if (state == S_HUNT || state == S_KILLED || state == S_ESCAPED)
         timer_nx = timer + TIMER_W'(1);
      else
         timer_nx = timer;

      enter_escape = (state_nx == S_ESCAPED) && (state != S_ESCAPED);

      score_nx = enemy_score;
      round_nx = round_cnt;
      if (state == S_IDLE && game_start) begin
         score_nx = '0;
         round_nx = '0;
      end
      if (enter_escape && enemy_score != SCORE_TOP)
         score_nx = enemy_score + 7'd1;
      // The round is only counted when NEXT completes, not when aborted
      if (state == S_NEXT && state_nx != S_IDLE && round_cnt < ROUND_TOP)
         round_nx = round_cnt + 7'd1;
   end

   // State, timer and registered output decode
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= S_IDLE;
         timer           <= '0;
         hunt_start      <= 1'b0;
         dog_bird_enable <= 1'b0;
         duck_escape     <= 1'b0;
         escape_pulse    <= 1'b0;
         rounds_done     <= 1'b0;
         round_cnt       <= '0;
         enemy_score     <= '0;
      end else begin
         state           <= state_nx;
         timer           <= timer_nx;
         hunt_start      <= (state_nx == S_HUNT);
         dog_bird_enable <= (state_nx == S_KILLED);
         duck_escape     <= (state_nx == S_ESCAPED);
         escape_pulse    <= enter_escape;
         rounds_done     <= (state_nx == S_DONE);
         round_cnt       <= round_nx;
         enemy_score     <= score_nx;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hunt_round_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hunt_round_ctl
//  Purpose  : Self-checking bench for hunt_round_ctl. Expected outputs come
//             from a round-level model: each round is described by when the
//             kill / ammo-out happens, and the bench derives the waveform of
//             every output cycle by cycle from that.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hunt_round_ctl;

   localparam int HC   = 10;
   localparam int SC   = 4;
   localparam int RC   = 3;
   localparam int SMAX = 99;

   logic       clk;
   logic       rst;
   logic       game_enable, game_start, intro_done, duck_killed, out_of_ammo;
   logic       hunt_start, dog_bird_enable, duck_escape, escape_pulse, rounds_done;
   logic [6:0] round_cnt, enemy_score;

   logic       sat_enable, sat_start, sat_intro, sat_zero;
   logic       sat_hunt, sat_dog, sat_esc, sat_pulse, sat_done;
   logic [6:0] sat_round, sat_score;

   int n_vec = 0;
   int n_err = 0;
   int m_round;
   int m_score;
   bit ended;

   hunt_round_ctl #(
      .HUNT_CYCLES(HC), .SHOW_CYCLES(SC), .ROUNDS(RC), .TIMER_W(32), .SCORE_MAX(SMAX)
   ) dut (
      .clk(clk), .rst(rst), .game_enable(game_enable), .game_start(game_start),
      .intro_done(intro_done), .duck_killed(duck_killed), .out_of_ammo(out_of_ammo),
      .hunt_start(hunt_start), .dog_bird_enable(dog_bird_enable),
      .duck_escape(duck_escape), .escape_pulse(escape_pulse),
      .round_cnt(round_cnt), .enemy_score(enemy_score), .rounds_done(rounds_done)
   );

   hunt_round_ctl #(
      .HUNT_CYCLES(3), .SHOW_CYCLES(2), .ROUNDS(127), .TIMER_W(8), .SCORE_MAX(SMAX)
   ) dut_sat (
      .clk(clk), .rst(rst), .game_enable(sat_enable), .game_start(sat_start),
      .intro_done(sat_intro), .duck_killed(sat_zero), .out_of_ammo(sat_zero),
      .hunt_start(sat_hunt), .dog_bird_enable(sat_dog),
      .duck_escape(sat_esc), .escape_pulse(sat_pulse),
      .round_cnt(sat_round), .enemy_score(sat_score), .rounds_done(sat_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence ever stalls
   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Compare all outputs of the main instance against flags plus model scores
   task automatic expect_a(input string tag, input logic h, input logic d,
                           input logic e, input logic p, input logic r);
      check(tag,
            {hunt_start, dog_bird_enable, duck_escape, escape_pulse, rounds_done,
             round_cnt, enemy_score},
            {h, d, e, p, r, 7'(m_round), 7'(m_score)});
   endtask

   task automatic start_game();
      game_enable = 1'b1;
      game_start  = 1'b1;
      tick();
      game_start  = 1'b0;
      m_round = 0;
      m_score = 0;
      expect_a("start_clear", 0, 0, 0, 0, 0);
      repeat ($urandom_range(0, 3)) begin
         tick();
         expect_a("intro_wait", 0, 0, 0, 0, 0);
      end
      intro_done = 1'b1;
      tick();
      intro_done = 1'b0;
   endtask

   // One round starting at the first HUNT cycle. kill_at / ammo_at are the
   // 1-based hunt cycles on which the input is raised (0 = never); abort_disp
   // drops game_enable on that display cycle (0 = never).
   task automatic play_round(input int kill_at, input int ammo_at,
                             input int abort_disp, output bit over);
      bit killed;
      killed = 1'b0;
      over   = 1'b0;
      for (int c = 1; c <= HC; c++) begin
         expect_a("hunt", 1, 0, 0, 0, 0);
         duck_killed = (c == kill_at);
         if (ammo_at != 0 && c >= ammo_at) out_of_ammo = 1'b1;
         game_start = 1'($urandom_range(0, 1));
         tick();
         duck_killed = 1'b0;
         game_start  = 1'b0;
         if (c == kill_at) begin
            killed = 1'b1;
            break;
         end
         if (out_of_ammo) break;
      end
      if (!killed && m_score < SMAX) m_score++;
      for (int d = 1; d <= SC; d++) begin
         expect_a("show", 0, killed, !killed, (d == 1) && !killed, 0);
         duck_killed = 1'($urandom_range(0, 1));
         if (d == abort_disp) game_enable = 1'b0;
         tick();
         duck_killed = 1'b0;
         if (d == abort_disp) begin
            expect_a("abort", 0, 0, 0, 0, 0);
            over = 1'b1;
            return;
         end
      end
      expect_a("next", 0, 0, 0, 0, 0);
      tick();
      m_round++;
      if (m_round == RC || out_of_ammo) begin
         expect_a("done", 0, 0, 0, 0, 1);
         over = 1'b1;
      end
   endtask

   task automatic end_game();
      out_of_ammo = 1'b0;
      repeat (2) begin
         tick();
         expect_a("done_hold", 0, 0, 0, 0, 1);
      end
      game_enable = 1'b0;
      tick();
      expect_a("idle_held", 0, 0, 0, 0, 0);
      tick();
      expect_a("idle_stay", 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1;
      game_enable = 0; game_start = 0; intro_done = 0; duck_killed = 0; out_of_ammo = 0;
      sat_enable = 0; sat_start = 0; sat_intro = 0; sat_zero = 0;
      m_round = 0;
      m_score = 0;
      #2 rst = 1'b0;
      #1 expect_a("reset", 0, 0, 0, 0, 0);
      tick();
      rst = 1'b1;

      // Start, reach HUNT, then asynchronous reset mid-hunt
      start_game();
      expect_a("intro_to_hunt", 1, 0, 0, 0, 0);
      repeat (3) tick();
      expect_a("hunt_mid", 1, 0, 0, 0, 0);
      #2 rst = 1'b0;
      #1 expect_a("async_reset", 0, 0, 0, 0, 0);
      tick();
      rst = 1'b1;
      game_enable = 1'b0;
      tick();

      // Game A: timeout escape, kill at 5, timeout escape
      start_game();
      play_round(0, 0, 0, ended);
      play_round(5, 0, 0, ended);
      play_round(0, 0, 0, ended);
      check("game_a_over", {18'd0, ended}, 19'd1);
      end_game();

      // Game B: kill on the timeout cycle, then ammo runs out
      start_game();
      play_round(HC, 0, 0, ended);
      play_round(0, $urandom_range(1, HC), 0, ended);
      check("game_b_over", {18'd0, ended}, 19'd1);
      end_game();

      // Game C: random kill timing (values above HC mean no kill)
      start_game();
      for (int r = 0; r < RC; r++) play_round($urandom_range(1, HC + 4), 0, 0, ended);
      check("game_c_over", {18'd0, ended}, 19'd1);
      end_game();

      // Game D: abort during the kill display
      start_game();
      play_round($urandom_range(1, HC - 1), 0, $urandom_range(1, SC), ended);
      check("game_d_abort", {18'd0, ended}, 19'd1);
      tick();
      expect_a("abort_idle", 0, 0, 0, 0, 0);

      // Saturation: every duck escapes; score must stop at SMAX
      sat_enable = 1'b1;
      sat_start  = 1'b1;
      tick();
      sat_start  = 1'b0;
      sat_intro  = 1'b1;
      tick();
      for (int k = 0; k <= 104; k++) begin
         check("sat_round", {4'd0, sat_hunt, sat_round, sat_score},
               {4'd0, 1'b1, 7'(k), 7'((k < SMAX) ? k : SMAX)});
         repeat (6) tick();
      end
      sat_enable = 1'b0;
      tick();
      check("sat_idle", {4'd0, sat_hunt, sat_round, sat_score},
            {4'd0, 1'b0, 7'd105, 7'(SMAX)});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
